iq_envelope: RTL
================

IQ_ENVELOPE -- requirements
Module: iq_envelope

Interface
REQ-001 SHALL have parameter DATA_W, 24, signed sample width of I/Q input and unsigned magnitude output width.
REQ-002 SHALL have parameter CH_BITS, 2, channel index width (4 channels).
REQ-003 SHALL have port s_axis_aclk  in  1  sole clock, all logic rising-edge.
REQ-004 SHALL have port s_axis_arstn  in  1  asynchronous active-low reset.
REQ-005 SHALL have port s_axis_tdata  in  DATA_W  signed I or Q sample from lowpass_fir.
REQ-006 SHALL have ports s_axis_tvalid in 1, s_axis_tready out 1, for the AXI-Stream input handshake.
REQ-007 SHALL have port s_axis_tuser  in  CH_BITS+1  bit[CH_BITS] 0=I, 1=Q; bits[CH_BITS-1:0] channel.
REQ-008 SHALL have port s_axis_tlast  in  1  frame marker, meaningful on Q beats.
REQ-009 SHALL have port m_axis_tdata  out  DATA_W  unsigned envelope magnitude.
REQ-010 SHALL have ports m_axis_tvalid out 1, m_axis_tready in 1, for the AXI-Stream output handshake.
REQ-011 SHALL have port m_axis_tuser  out  CH_BITS  channel of the magnitude.
REQ-012 SHALL have port m_axis_tlast  out  1  tlast copied from the producing Q beat.
REQ-013 SHALL have port err_pulse  out  1  one-cycle pulse on a pairing violation.

Function
REQ-014 SHALL keep a per-channel I store (DATA_W value plus valid bit), 2^CH_BITS entries.
REQ-015 An accepted I beat SHALL write the store for its channel, set valid, and produce no output.
REQ-016 An accepted I beat on a channel whose valid is already set SHALL overwrite the value and pulse err_pulse.
REQ-017 An accepted Q beat with the channel's valid set SHALL clear valid and launch one magnitude computation.
REQ-018 An accepted Q beat with the channel's valid clear SHALL be dropped with no output and SHALL pulse err_pulse.
REQ-019 Magnitude SHALL be max(|I|,|Q|) + (min(|I|,|Q|)>>2) + (min(|I|,|Q|)>>3), with floor shifts and |x| computed at DATA_W bits unsigned (|-2^(DATA_W-1)| = 2^(DATA_W-1)).
REQ-020 The result SHALL fit DATA_W unsigned bits with no saturation (maximum 11534336 at DATA_W=24).
REQ-021 Pipeline SHALL be 2 stages: stage 1 computes abs/compare, stage 2 sums into the output register; m_axis_tvalid SHALL rise 2 cycles after Q acceptance when unstalled.
REQ-022 Global enable SHALL be en = !m_axis_tvalid | m_axis_tready; s_axis_tready SHALL equal en; both stages advance only when en is high.
REQ-023 While m_axis_tvalid is high and m_axis_tready is low, m_axis_tdata/tuser/tlast SHALL hold stable.
REQ-024 Full throughput SHALL be one input beat per cycle when m_axis_tready is held high.
REQ-025 I and Q beats of different channels MAY interleave; pairing SHALL be strictly per channel.

Reset
REQ-026 On s_axis_arstn low, asynchronously: all store valid bits, both stage valids, m_axis_tvalid and err_pulse SHALL become 0; s_axis_tready SHALL be 1 after reset release.
REQ-027 Reset mid-operation SHALL discard stored I values and in-flight results; the first Q beat after reset on any channel SHALL be treated per REQ-018.
REQ-028 m_axis_tdata, m_axis_tuser and m_axis_tlast SHALL reset to 0.

Structure
REQ-029 DATA_W, CH_BITS defaults and the tuser I/Q bit position SHALL live in the shared sonar_pkg package, shared with demod and lowpass_fir.
REQ-030 The abs/max/min/alpha-beta arithmetic SHALL be one combinational sub-module, amb_mag, instantiated in stage 1/2; there SHALL be no other sub-modules.

Verification
REQ-031 Pairing: ch1 I=3000 then Q=4000, tready=1 -> one output of 5125 with tuser=1, two cycles after the Q beat.
REQ-032 Extremes: I=-8388608, Q=0 -> 8388608; I=Q=-8388608 -> 11534336; I=Q=0 -> 0.
REQ-033 Errors: ch2 Q with no prior I -> err_pulse=1 and no output; ch0 I, I, Q -> one err_pulse and output using the second I.
REQ-034 Backpressure: random m_tready, 10k interleaved 4-channel I/Q beats -> outputs match the reference model in order, and data stays stable while stalled.
REQ-035 Reset: assert s_axis_arstn low between ch3 I and Q -> no output, and Q after release -> err_pulse; tlast=1 on a Q beat -> m_axis_tlast=1 on its output only.

Source files
------------

// File: rtl/sonar_pkg.sv
// -----------------------------------------------------------------------------
// sonar_pkg
// Shared definitions for the sonar receive chain (demod, lowpass_fir,
// iq_envelope): default sample/channel widths and the layout of the
// AXI-Stream tuser field that tags each beat as I or Q plus its channel.
// No ports.
// -----------------------------------------------------------------------------
package sonar_pkg;

  localparam int DATA_W_DEF  = 24;
  localparam int CH_BITS_DEF = 2;

  // tuser layout: {iq_sel, channel[CH_BITS-1:0]}
  typedef enum logic {
    IQ_I = 1'b0,
    IQ_Q = 1'b1
  } iq_sel_e;

  // The I/Q flag sits directly above the channel field.
  function automatic int iq_bit_pos(input int ch_bits);
    return ch_bits;
  endfunction

  localparam int IQ_BIT_DEF = iq_bit_pos(CH_BITS_DEF);

endpackage

// File: rtl/amb_mag.sv
// -----------------------------------------------------------------------------
// amb_mag
// Combinational alpha-max-beta-min magnitude estimate:
//   mag = max(|i|,|q|) + (min(|i|,|q|) >> 2) + (min(|i|,|q|) >> 3)
// Absolute values are taken at DATA_W unsigned bits, so the most negative
// input maps to 2^(DATA_W-1). The worst case (both inputs most negative) is
// 1.375 * 2^(DATA_W-1), which still fits DATA_W unsigned bits.
// Ports:
//   i_val  in  DATA_W signed   in-phase sample
//   q_val  in  DATA_W signed   quadrature sample
//   mag    out DATA_W unsigned envelope estimate
// -----------------------------------------------------------------------------
module amb_mag
  import sonar_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic signed [DATA_W-1:0] i_val,
  input  logic signed [DATA_W-1:0] q_val,
  output logic        [DATA_W-1:0] mag
);

  function automatic logic [DATA_W-1:0] abs_u(input logic signed [DATA_W-1:0] x);
    logic [DATA_W-1:0] ux;
    logic [DATA_W-1:0] ux_n;
    ux   = x;
    ux_n = ~ux;
    return x[DATA_W-1] ? (ux_n + DATA_W'(1)) : ux;
  endfunction

  logic [DATA_W-1:0] abs_i;
  logic [DATA_W-1:0] abs_q;
  logic [DATA_W-1:0] mx;
  logic [DATA_W-1:0] mn;

  always_comb begin
    abs_i = abs_u(i_val);
    abs_q = abs_u(q_val);
    if (abs_i >= abs_q) begin
      mx = abs_i;
      mn = abs_q;
    end else begin
      mx = abs_q;
      mn = abs_i;
    end
    mag = mx + (mn >> 2) + (mn >> 3);
  end

endmodule

// File: rtl/iq_envelope.sv
// -----------------------------------------------------------------------------
// iq_envelope
// Pairs interleaved per-channel I and Q beats and emits the envelope magnitude
// of each pair. An I beat is parked in a per-channel store; the matching Q beat
// launches the pair into a two-stage pipeline (capture, then magnitude into the
// output register). Pairing violations (I over a pending I, Q with no pending I)
// raise a one-cycle err_pulse; an orphan Q is dropped.
// Ports:
//   s_axis_aclk    in   clock, rising edge
//   s_axis_arstn   in   asynchronous active-low reset
//   s_axis_tdata   in   DATA_W signed I or Q sample
//   s_axis_tvalid  in   input beat valid
//   s_axis_tready  out  input ready (global pipeline enable)
//   s_axis_tuser   in   {iq_sel, channel}
//   s_axis_tlast   in   frame marker, used on Q beats
//   m_axis_tdata   out  DATA_W unsigned magnitude
//   m_axis_tvalid  out  output valid
//   m_axis_tready  in   output ready
//   m_axis_tuser   out  channel of the magnitude
//   m_axis_tlast   out  tlast of the producing Q beat
//   err_pulse      out  one-cycle pairing-violation pulse
// -----------------------------------------------------------------------------
module iq_envelope
  import sonar_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CH_BITS = CH_BITS_DEF
) (
  input  logic                      s_axis_aclk,
  input  logic                      s_axis_arstn,
  input  logic signed [DATA_W-1:0]  s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic        [CH_BITS:0]   s_axis_tuser,
  input  logic                      s_axis_tlast,
  output logic        [DATA_W-1:0]  m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic        [CH_BITS-1:0] m_axis_tuser,
  output logic                      m_axis_tlast,
  output logic                      err_pulse
);

  localparam int N_CH   = 1 << CH_BITS;
  localparam int IQ_POS = iq_bit_pos(CH_BITS);

  logic                     en;
  logic                     acc;
  logic                     is_q;
  logic [CH_BITS-1:0]       ch;
  logic                     launch;
  logic                     pair_err;

  logic signed [DATA_W-1:0] i_store [N_CH];
  logic [N_CH-1:0]          i_vld;

  logic                     vld_p1;
  logic signed [DATA_W-1:0] i_p1;
  logic signed [DATA_W-1:0] q_p1;
  logic [CH_BITS-1:0]       ch_p1;
  logic                     last_p1;
  logic [DATA_W-1:0]        mag_p1;

  // The whole pipeline stalls only when the output register holds an
  // unaccepted result; input ready is that same enable.
  assign en            = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = en;
  assign acc           = s_axis_tvalid && en;
  assign ch            = s_axis_tuser[CH_BITS-1:0];
  assign is_q          = (s_axis_tuser[IQ_POS] == IQ_Q);
  assign launch        = acc && is_q && i_vld[ch];
  assign pair_err      = acc && (is_q ? !i_vld[ch] : i_vld[ch]);

  // ---- control: store valids, stage valids, output register, error pulse ----
  always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
    if (!s_axis_arstn) begin
      i_vld         <= '0;
      vld_p1        <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
      err_pulse     <= 1'b0;
    end else begin
      err_pulse <= pair_err;
      // An I beat marks its channel pending; any Q beat leaves it empty.
      if (acc) begin
        i_vld[ch] <= !is_q;
      end
      if (en) begin
        vld_p1        <= launch;
        m_axis_tvalid <= vld_p1;
        if (vld_p1) begin
          m_axis_tdata <= mag_p1;
          m_axis_tuser <= ch_p1;
          m_axis_tlast <= last_p1;
        end
      end
    end
  end

  // ---- stage 0 -> 1: park I samples, capture the I/Q pair on launch ----
  always_ff @(posedge s_axis_aclk) begin
    if (acc && !is_q) begin
      i_store[ch] <= s_axis_tdata;
    end
    if (launch) begin
      i_p1    <= i_store[ch];
      q_p1    <= s_axis_tdata;
      ch_p1   <= ch;
      last_p1 <= s_axis_tlast;
    end
  end

  // ---- stage 1 -> 2: magnitude of the captured pair feeds the output register ----
  amb_mag #(
    .DATA_W (DATA_W)
  ) u_amb_mag (
    .i_val (i_p1),
    .q_val (q_p1),
    .mag   (mag_p1)
  );

endmodule
